// File: rtl/key_event_generator.sv
// -----------------------------------------------------------------------------
// key_event_generator
//
// Conditions the raw push-button lines for the egg-timer control logic. For
// each key it:
//   * brings the active-low, asynchronous KEY line into the clk domain through
//     a two-flop synchroniser,
//   * debounces the synchronised level so that only a level held for
//     DEBOUNCE_CYCLES consecutive cycles is accepted,
//   * emits registered one-cycle press / release pulses aligned with the
//     debounced level change,
//   * optionally emits hold-to-auto-repeat pulses: the first one REPEAT_DELAY
//     cycles after the press pulse, then one every REPEAT_PERIOD cycles.
//
// Downstream logic consumes the pulses directly; no further edge detection is
// needed. Every output comes straight from a flop, so there is no
// combinational path from any input to any output.
//
// Parameters (each of the three cycle counts must be at least 2):
//   NUM_KEYS         number of independent key channels
//   DEBOUNCE_CYCLES  cycles a new synchronised level must persist
//   REPEAT_DELAY     cycles from the press pulse to the first repeat pulse
//   REPEAT_PERIOD    cycles between successive repeat pulses
//
// Ports:
//   clk          system clock
//   reset_n      asynchronous, active-low reset; clears all progress
//   key_n        raw button lines, active-low, asynchronous to clk
//   repeat_en    per-key auto-repeat enable, synchronous to clk
//   key_level    debounced pressed state, active-high
//   key_press    one-cycle pulse when a key becomes debounced-pressed
//   key_release  one-cycle pulse when a key becomes debounced-released
//   key_repeat   one-cycle auto-repeat pulse while held with repeat_en=1
//
// Latency: a clean raw edge appears on key_level / key_press exactly
// 2 + DEBOUNCE_CYCLES cycles after the first clk edge that samples it
// (two synchroniser stages, DEBOUNCE_CYCLES of debounce, one output stage).
// -----------------------------------------------------------------------------
module key_event_generator #(
    parameter int NUM_KEYS        = 4,
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int REPEAT_DELAY    = 25000000,
    parameter int REPEAT_PERIOD   = 5000000
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic [NUM_KEYS-1:0] key_n,
    input  logic [NUM_KEYS-1:0] repeat_en,
    output logic [NUM_KEYS-1:0] key_level,
    output logic [NUM_KEYS-1:0] key_press,
    output logic [NUM_KEYS-1:0] key_release,
    output logic [NUM_KEYS-1:0] key_repeat
);

    // Debounce counter only has to reach DEBOUNCE_CYCLES-1, so it never wraps.
    localparam int DB_W = $clog2(DEBOUNCE_CYCLES);

    // One repeat counter serves both the initial delay and the period.
    localparam int RPT_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY
                                                            : REPEAT_PERIOD;
    localparam int RPT_W   = $clog2(RPT_MAX);

    localparam logic [DB_W-1:0]  DB_LAST     = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [RPT_W-1:0] DELAY_LAST  = RPT_W'(REPEAT_DELAY - 1);
    localparam logic [RPT_W-1:0] PERIOD_LAST = RPT_W'(REPEAT_PERIOD - 1);

    // IDLE   : key released, no repeat activity
    // HOLD   : key held, counting towards the first repeat (or parked at the
    //          last count while repeat is disabled)
    // REPEAT : key held and repeating every REPEAT_PERIOD cycles
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_HOLD   = 2'd1,
        ST_REPEAT = 2'd2
    } rpt_state_e;

    for (genvar i = 0; i < NUM_KEYS; i++) begin : g_key

        // ---------------------------------------------------------------
        // Per-key state
        // ---------------------------------------------------------------
        logic             sync1_n;   // first synchroniser stage (raw polarity)
        logic             sync2_n;   // second synchroniser stage (raw polarity)
        logic             pressed;   // synchronised level, active-high
        logic             stable;    // accepted (debounced) level
        logic [DB_W-1:0]  db_cnt;    // cycles the synchronised level has differed

        logic             level_q;
        logic             press_q;
        logic             release_q;
        logic             repeat_q;
        rpt_state_e       state;
        logic [RPT_W-1:0] rpt_cnt;

        logic             rise;      // stable went 0->1 on the last edge
        logic             fall;      // stable went 1->0 on the last edge

        assign pressed = ~sync2_n;

        // level_q trails stable by one cycle, so a difference between the
        // two marks the cycle in which the output stage must pulse.
        assign rise = stable & ~level_q;
        assign fall = ~stable & level_q;

        // ---------------------------------------------------------------
        // Two-flop synchroniser. Reset to the released level (line high)
        // so that a key held through reset is seen as a fresh press.
        // ---------------------------------------------------------------
        // NOTE: sequential state always uses non-blocking assignments so
        // every flop samples the pre-edge value of its neighbours; blocking
        // here would collapse the two synchroniser stages into one.
        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
                sync1_n <= 1'b1;
                sync2_n <= 1'b1;
            end else begin
                sync1_n <= key_n[i];
                sync2_n <= sync1_n;
            end
        end

        // ---------------------------------------------------------------
        // Debounce: any return to the accepted level restarts the count,
        // so only an uninterrupted run of DEBOUNCE_CYCLES differing cycles
        // toggles the accepted level.
        // ---------------------------------------------------------------
        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
                stable <= 1'b0;
                db_cnt <= '0;
            end else if (pressed == stable) begin
                db_cnt <= '0;
            end else if (db_cnt == DB_LAST) begin
                stable <= pressed;
                db_cnt <= '0;
            end else begin
                db_cnt <= db_cnt + 1'b1;
            end
        end

        // ---------------------------------------------------------------
        // Output stage and auto-repeat FSM. The FSM reacts to the same
        // rise / fall conditions that load press_q / release_q, so its
        // transitions line up with the press / release pulses: the counter
        // is 0 in the press cycle and the first repeat lands exactly
        // REPEAT_DELAY cycles later.
        // ---------------------------------------------------------------
        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
                level_q   <= 1'b0;
                press_q   <= 1'b0;
                release_q <= 1'b0;
                repeat_q  <= 1'b0;
                state     <= ST_IDLE;
                rpt_cnt   <= '0;
            end else begin
                level_q   <= stable;
                press_q   <= rise;
                release_q <= fall;
                repeat_q  <= 1'b0;

                unique case (state)
                    ST_IDLE: begin
                        if (rise) begin
                            state   <= ST_HOLD;
                            rpt_cnt <= '0;
                        end
                    end

                    ST_HOLD: begin
                        if (fall) begin
                            // Release wins over any repeat due this cycle.
                            state   <= ST_IDLE;
                            rpt_cnt <= '0;
                        end else if (rpt_cnt == DELAY_LAST) begin
                            // With repeat disabled the counter parks here,
                            // so enabling repeat fires on the next edge.
                            if (repeat_en[i]) begin
                                repeat_q <= 1'b1;
                                rpt_cnt  <= '0;
                                state    <= ST_REPEAT;
                            end
                        end else begin
                            rpt_cnt <= rpt_cnt + 1'b1;
                        end
                    end

                    ST_REPEAT: begin
                        if (fall) begin
                            state   <= ST_IDLE;
                            rpt_cnt <= '0;
                        end else if (!repeat_en[i]) begin
                            // Park in HOLD at the saturated count so pulses
                            // stop and resume one cycle after re-enable.
                            state   <= ST_HOLD;
                            rpt_cnt <= DELAY_LAST;
                        end else if (rpt_cnt == PERIOD_LAST) begin
                            repeat_q <= 1'b1;
                            rpt_cnt  <= '0;
                        end else begin
                            rpt_cnt <= rpt_cnt + 1'b1;
                        end
                    end

                    default: begin
                        state   <= ST_IDLE;
                        rpt_cnt <= '0;
                    end
                endcase
            end
        end

        assign key_level[i]   = level_q;
        assign key_press[i]   = press_q;
        assign key_release[i] = release_q;
        assign key_repeat[i]  = repeat_q;

    end : g_key

endmodule : key_event_generator

// File: tb/tb_key_event_generator.sv
// -----------------------------------------------------------------------------
// tb_key_event_generator
//
// Directed bench for key_event_generator with small timing parameters.
// Expected pulses are pushed into a cycle-ordered scoreboard when stimulus is
// driven; a negedge monitor pops the entry due in the current cycle and
// compares all pulse outputs (no entry means no pulse may be present).
// Levels are compared directly at chosen cycles.
// -----------------------------------------------------------------------------
module tb_key_event_generator;

    localparam int NK  = 4;
    localparam int DB  = 4;
    localparam int RD  = 10;
    localparam int RP  = 3;
    // Cycles from the bench driving key_n (just after edge n) to the output
    // change: one edge to be sampled, then 2 + DB.
    localparam int LAT = DB + 3;

    localparam int K_PRESS   = 0;
    localparam int K_RELEASE = 1;
    localparam int K_REPEAT  = 2;

    logic          clk = 1'b0;
    logic          reset_n;
    logic [NK-1:0] key_n;
    logic [NK-1:0] repeat_en;
    logic [NK-1:0] key_level;
    logic [NK-1:0] key_press;
    logic [NK-1:0] key_release;
    logic [NK-1:0] key_repeat;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    typedef struct {
        int            cyc;
        logic [NK-1:0] prs;
        logic [NK-1:0] rel;
        logic [NK-1:0] rep;
    } exp_t;

    exp_t sb[$];

    key_event_generator #(
        .NUM_KEYS        (NK),
        .DEBOUNCE_CYCLES (DB),
        .REPEAT_DELAY    (RD),
        .REPEAT_PERIOD   (RP)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .key_n       (key_n),
        .repeat_en   (repeat_en),
        .key_level   (key_level),
        .key_press   (key_press),
        .key_release (key_release),
        .key_repeat  (key_repeat)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Add one expected pulse, merging with an entry for the same cycle and
    // keeping the queue ordered by cycle.
    task automatic expect_pulse(input int c, input int kind, input int k);
        exp_t e;
        int   idx;
        bit   found;
        bit   merge;
        idx   = sb.size();
        found = 1'b0;
        for (int i = 0; i < sb.size(); i++) begin
            if (!found && sb[i].cyc >= c) begin
                idx   = i;
                found = 1'b1;
            end
        end
        merge = found && (sb[idx].cyc == c);
        if (merge) begin
            e = sb[idx];
        end else begin
            e.cyc = c;
            e.prs = '0;
            e.rel = '0;
            e.rep = '0;
        end
        case (kind)
            K_PRESS:   e.prs[k] = 1'b1;
            K_RELEASE: e.rel[k] = 1'b1;
            default:   e.rep[k] = 1'b1;
        endcase
        if (merge) sb[idx] = e;
        else       sb.insert(idx, e);
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    // Advance to just after the edge that makes cyc == target.
    task automatic wait_until(input int target);
        while (cyc < target) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Pulse monitor: every cycle, the pulse outputs must equal the entry due
    // in this cycle, or be all zero when nothing is due.
    always @(negedge clk) begin
        exp_t e;
        e.cyc = cyc;
        e.prs = '0;
        e.rel = '0;
        e.rep = '0;
        if (sb.size() > 0 && sb[0].cyc == cyc) e = sb.pop_front();
        checks++;
        assert ({key_press, key_release, key_repeat} === {e.prs, e.rel, e.rep}) else begin
            errors++;
            $error("FAIL pulses cycle %0d: observed press=%b release=%b repeat=%b expected press=%b release=%b repeat=%b",
                   cyc, key_press, key_release, key_repeat, e.prs, e.rel, e.rep);
        end
    end

    initial begin
        int n;
        int k;
        int r;

        // ---- reset, then idle ------------------------------------------
        reset_n   = 1'b0;
        key_n     = '1;
        repeat_en = '0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_outputs", {key_level, key_press, key_release, key_repeat}, 32'h0);
        reset_n = 1'b1;
        wait_until(cyc + 50);
        check("idle_level", key_level, 32'h0);

        // ---- clean press / release on key0 -----------------------------
        n = cyc;
        key_n[0] = 1'b0;
        expect_pulse(n + LAT, K_PRESS, 0);
        wait_until(n + LAT - 1);
        check("key0_level_before_press", key_level, 32'h0);
        wait_until(n + LAT);
        check("key0_level_pressed", key_level, 32'h1);
        wait_until(n + LAT + 20);
        n = cyc;
        key_n[0] = 1'b1;
        expect_pulse(n + LAT, K_RELEASE, 0);
        wait_until(n + LAT - 1);
        check("key0_level_before_release", key_level, 32'h1);
        wait_until(n + LAT);
        check("key0_level_released", key_level, 32'h0);

        // ---- bounce rejection on key1 ----------------------------------
        for (int i = 0; i < 4; i++) begin
            key_n[1] = 1'b0;
            wait_until(cyc + 2);
            key_n[1] = 1'b1;
            wait_until(cyc + 2);
        end
        wait_until(cyc + 10);
        check("key1_bounce_level", key_level, 32'h0);

        // Glitch one cycle shorter than the debounce window: ignored.
        n = cyc;
        key_n[1] = 1'b0;
        wait_until(n + DB - 1);
        key_n[1] = 1'b1;
        wait_until(cyc + 10);
        check("key1_short_glitch_level", key_level, 32'h0);

        // Pulse exactly as long as the debounce window: accepted.
        n = cyc;
        key_n[1] = 1'b0;
        expect_pulse(n + LAT, K_PRESS, 1);
        wait_until(n + DB);
        key_n[1] = 1'b1;
        expect_pulse(n + DB + LAT, K_RELEASE, 1);
        wait_until(n + LAT);
        check("key1_min_pulse_level", key_level, 32'h2);
        wait_until(n + DB + LAT);
        check("key1_min_pulse_released", key_level, 32'h0);

        // ---- auto-repeat on key2, release on a would-be repeat cycle ---
        repeat_en = 4'b0100;
        n = cyc;
        key_n[2] = 1'b0;
        k = n + LAT;
        expect_pulse(k, K_PRESS, 2);
        for (int j = 0; j < 7; j++) expect_pulse(k + RD + j * RP, K_REPEAT, 2);
        wait_until(k + 24);
        key_n[2] = 1'b1;
        expect_pulse(k + 24 + LAT, K_RELEASE, 2);
        wait_until(k + 24 + LAT);
        check("key2_repeat_released", key_level, 32'h0);

        // ---- same hold with repeat disabled ----------------------------
        repeat_en = '0;
        wait_until(cyc + 5);
        n = cyc;
        key_n[2] = 1'b0;
        k = n + LAT;
        expect_pulse(k, K_PRESS, 2);
        wait_until(k + 24);
        check("key2_norepeat_level", key_level, 32'h4);
        key_n[2] = 1'b1;
        expect_pulse(k + 24 + LAT, K_RELEASE, 2);
        wait_until(k + 24 + LAT);
        check("key2_norepeat_released", key_level, 32'h0);

        // ---- repeat_en toggled during a hold ---------------------------
        wait_until(cyc + 5);
        n = cyc;
        key_n[2] = 1'b0;
        k = n + LAT;
        expect_pulse(k, K_PRESS, 2);
        wait_until(k + 15);
        repeat_en[2] = 1'b1;
        expect_pulse(k + 16, K_REPEAT, 2);
        expect_pulse(k + 19, K_REPEAT, 2);
        expect_pulse(k + 22, K_REPEAT, 2);
        wait_until(k + 23);
        repeat_en[2] = 1'b0;
        wait_until(k + 27);
        repeat_en[2] = 1'b1;
        expect_pulse(k + 28, K_REPEAT, 2);
        wait_until(k + 28);
        key_n[2] = 1'b1;
        expect_pulse(k + 31, K_REPEAT, 2);
        expect_pulse(k + 34, K_REPEAT, 2);
        expect_pulse(k + 28 + LAT, K_RELEASE, 2);
        wait_until(k + 28 + LAT);
        check("key2_toggle_released", key_level, 32'h0);
        repeat_en = '0;

        // ---- simultaneous keys plus reset mid-hold ---------------------
        wait_until(cyc + 5);
        n = cyc;
        key_n[0] = 1'b0;
        key_n[3] = 1'b0;
        expect_pulse(n + LAT, K_PRESS, 0);
        expect_pulse(n + LAT, K_PRESS, 3);
        wait_until(n + LAT);
        check("keys03_level", key_level, 32'h9);
        wait_until(n + LAT + 3);
        reset_n = 1'b0;
        #1;
        check("mid_hold_reset_outputs", {key_level, key_press, key_release, key_repeat}, 32'h0);
        wait_until(cyc + 3);
        r = cyc;
        reset_n = 1'b1;
        expect_pulse(r + LAT, K_PRESS, 0);
        expect_pulse(r + LAT, K_PRESS, 3);
        wait_until(r + LAT - 1);
        check("after_reset_level_before", key_level, 32'h0);
        wait_until(r + LAT);
        check("after_reset_level_pressed", key_level, 32'h9);
        wait_until(cyc + 5);
        n = cyc;
        key_n = '1;
        expect_pulse(n + LAT, K_RELEASE, 0);
        expect_pulse(n + LAT, K_RELEASE, 3);
        wait_until(n + LAT);
        check("keys03_released", key_level, 32'h0);

        wait_until(cyc + 10);
        check("scoreboard_drained", sb.size(), 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_key_event_generator

// File: doc/key_event_generator.md
Name: key_event_generator

Overview:
- Input conditioner between the board push-buttons and the egg-timer control logic.
- Per key: synchronises the raw active-low KEY line, debounces it, and emits clean one-cycle press and release pulses.
- Optional per key: hold-to-auto-repeat pulses, used for fast minute/second stepping while setting the timer.
- Output pulses feed the toggle flip-flops and setting logic directly; no further edge detection is required downstream.

Parameters:
- NUM_KEYS, 4: number of independent key channels.
- DEBOUNCE_CYCLES, 1000000: cycles the synchronised input must hold a new level before it is accepted (20 ms at 50 MHz); minimum 2.
- REPEAT_DELAY, 25000000: cycles of continuous debounced hold, counted from the press pulse, before the first repeat pulse (500 ms); minimum 2.
- REPEAT_PERIOD, 5000000: cycles between successive repeat pulses (100 ms); minimum 2.

Ports:
- clk  input  1  system clock, 50 MHz board clock.
- reset_n  input  1  asynchronous, active-low reset.
- key_n  input  NUM_KEYS  raw button lines, active-low (0 = pressed), asynchronous to clk.
- repeat_en  input  NUM_KEYS  per-key auto-repeat enable, synchronous to clk.
- key_level  output  NUM_KEYS  debounced pressed state, active-high.
- key_press  output  NUM_KEYS  one-cycle pulse when a key becomes debounced-pressed.
- key_release  output  NUM_KEYS  one-cycle pulse when a key becomes debounced-released.
- key_repeat  output  NUM_KEYS  one-cycle auto-repeat pulse while held with repeat_en=1.

Behaviour:
- Reset:
  - reset_n=0 asynchronously clears all state.
  - Synchroniser flops reset to 1 (released).
  - Debounce and repeat counters reset to 0.
  - Per-key FSM resets to IDLE.
  - key_level, key_press, key_release and key_repeat all reset to 0.
  - Reset asserted mid-hold or mid-debounce discards all progress. After release of reset, a key still held is re-debounced and yields a fresh key_press.
- Synchroniser: two flops per key; s = ~key_n after two clk edges.
- Debounce, per key, with registered stable level L:
  - If s == L, the counter clears to 0.
  - Otherwise the counter increments.
  - When the counter equals DEBOUNCE_CYCLES-1 and s != L, L toggles and the counter clears.
  - Any glitch shorter than DEBOUNCE_CYCLES cycles produces no output.
  - Counter width: $clog2(DEBOUNCE_CYCLES). The counter never wraps.
- key_level = L (registered).
  - key_press is high for exactly the cycle in which L transitions 0->1.
  - key_release is high for exactly the cycle in which L transitions 1->0.
  - Both are registered outputs, aligned with the key_level change.
- Latency: a clean raw edge reaches key_level/key_press exactly 2 + DEBOUNCE_CYCLES cycles after the first clk edge that samples the new level.
- Per-key repeat FSM, states IDLE, HOLD, REPEAT:
  - IDLE -> HOLD on key_press; repeat counter cleared.
  - HOLD: counter increments each cycle. When it reaches REPEAT_DELAY-1 and repeat_en=1, assert key_repeat, clear the counter, go to REPEAT. If repeat_en=0, the counter saturates at REPEAT_DELAY-1 and no pulse is emitted.
  - REPEAT: counter increments. At REPEAT_PERIOD-1, assert key_repeat and clear the counter.
  - HOLD or REPEAT -> IDLE on key_release, regardless of counter state; no repeat pulse is issued in the release cycle.
  - repeat_en falling to 0 in REPEAT: return to HOLD with the counter saturated, so pulses stop. Pulses resume one cycle after repeat_en returns to 1.
  - Repeat counter width: $clog2(max(REPEAT_DELAY, REPEAT_PERIOD)).
- key_press and key_repeat are never high in the same cycle for one key.
- The first repeat occurs exactly REPEAT_DELAY cycles after key_press.
- Keys are fully independent. Simultaneous presses on several keys produce pulses in the same cycle on each bit.
- No combinational path from any input to any output.

Test Plan (DEBOUNCE_CYCLES=4, REPEAT_DELAY=10, REPEAT_PERIOD=3, NUM_KEYS=4):
- Reset then idle: reset_n=0 for 3 cycles, key_n=4'hF -> all outputs 0. No pulses for 50 cycles after reset_n=1.
- Clean press/release on key0: key_n[0] 1->0 held 20 cycles, then 0->1 -> key_press[0] single pulse 6 cycles after the sampling edge, key_level[0]=1; key_release[0] single pulse 6 cycles after release, key_level[0]=0.
- Bounce rejection: key_n[1] toggles 0/1 every 2 cycles for 16 cycles, then stays 1 -> no pulses, key_level[1] stays 0.
- Auto-repeat: repeat_en[2]=1, key2 held 30 cycles after key_press -> key_repeat[2] at +10, +13, +16, +19, +22, +25, +28; stops on key_release. Same hold with repeat_en[2]=0 -> no key_repeat.
- Simultaneous keys plus mid-operation reset: key0 and key3 pressed on the same edge -> key_press[0] and key_press[3] in the same cycle. Assert reset_n=0 during the hold -> outputs 0 immediately; after reset_n=1 with keys still held, key_press re-fires 6 cycles later.
